// File: rtl/tile_display_arbiter_if.sv
// Tile pin bundle for the display arbiter.
// The arbiter is the slave; the tile harness drives it as master.
interface tile_display_arbiter_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );
endinterface

// File: rtl/tile_display_arbiter.sv
// Round-robin arbiter sharing the 7-segment display among three requesters.
// Each grant holds for a fixed window and is followed by a blank gap.
module tile_display_arbiter #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  tile_display_arbiter_if.slave tile
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_t;

  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LD  =
    (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [2:0] grant, grant_nx;
  logic [1:0] ptr, ptr_nx;
  logic [1:0] ptr_after;
  logic [2:0] req_m, req_s;
  logic [2:0] rot, rot_oh, win_oh;
  logic [6:0] seg;
  logic       hold_end;
  logic       unused_pins;

  assign unused_pins = ^{tile.uio_in, tile.ui_in[7],
                         tile.ui_in[5:3], tile.ui_in[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_m <= '0;
      req_s <= '0;
    end else if (ena) begin
      req_m <= {tile.ui_in[6], tile.ui_in[2], tile.ui_in[0]};
      req_s <= req_m;
    end
  end

  // Rotate so bit 0 is the requester at ptr, pick lowest, rotate back.
  always_comb begin
    rot = req_s;
    unique case (ptr)
      2'd1:    rot = {req_s[0], req_s[2], req_s[1]};
      2'd2:    rot = {req_s[1], req_s[0], req_s[2]};
      default: rot = req_s;
    endcase
    rot_oh[0] = rot[0];
    rot_oh[1] = rot[1] & ~rot[0];
    rot_oh[2] = rot[2] & ~rot[1] & ~rot[0];
    win_oh = rot_oh;
    unique case (ptr)
      2'd1:    win_oh = {rot_oh[1], rot_oh[0], rot_oh[2]};
      2'd2:    win_oh = {rot_oh[0], rot_oh[2], rot_oh[1]};
      default: win_oh = rot_oh;
    endcase
  end

  always_comb begin
    ptr_after = ptr;
    unique case (1'b1)
      grant[0]: ptr_after = 2'd1;
      grant[1]: ptr_after = 2'd2;
      grant[2]: ptr_after = 2'd0;
      default:  ptr_after = ptr;
    endcase
  end

  assign hold_end = ~|(req_s & grant) | (cnt == 8'd0);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    grant_nx = grant;
    ptr_nx   = ptr;
    case (state)
      IDLE: begin
        if (|req_s) begin
          grant_nx = win_oh;
          cnt_nx   = HOLD_LD;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (hold_end) begin
          grant_nx = '0;
          ptr_nx   = ptr_after;
          if (GAP_CYCLES == 0) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            state_nx = GAP;
            cnt_nx   = GAP_LD;
          end
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      GAP: begin
        if (cnt == 8'd0) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      grant <= '0;
      ptr   <= '0;
    end else if (ena) begin
      state <= state_nx;
      cnt   <= cnt_nx;
      grant <= grant_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    seg = 7'h00;
    if (state == GRANT) begin
      unique case (1'b1)
        grant[0]: seg = 7'h3F;
        grant[1]: seg = 7'h06;
        grant[2]: seg = 7'h5B;
        default:  seg = 7'h00;
      endcase
    end
  end

  assign tile.uo_out  = {state != IDLE, seg};
  assign tile.uio_out = {3'b000, state, grant};
  assign tile.uio_oe  = 8'h1F;

endmodule
